// File: rtl/video_pkg.sv
// Shared state type, standard raster timing sets and period helper for the
// video timing controller.
package video_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} t_vid_state;

  function automatic int vid_total(input int active, input int front,
                                   input int sync, input int back);
    return active + front + sync + back;
  endfunction

  // 1920x1080 @ 60 Hz
  localparam int VID1080_HPIX    = 1920;
  localparam int VID1080_H_FRONT = 88;
  localparam int VID1080_H_SYNC  = 44;
  localparam int VID1080_H_BACK  = 148;
  localparam int VID1080_VPIX    = 1080;
  localparam int VID1080_V_FRONT = 4;
  localparam int VID1080_V_SYNC  = 5;
  localparam int VID1080_V_BACK  = 36;

  // 1280x720 @ 60 Hz
  localparam int VID720_HPIX     = 1280;
  localparam int VID720_H_FRONT  = 110;
  localparam int VID720_H_SYNC   = 40;
  localparam int VID720_H_BACK   = 220;
  localparam int VID720_VPIX     = 720;
  localparam int VID720_V_FRONT  = 5;
  localparam int VID720_V_SYNC   = 5;
  localparam int VID720_V_BACK   = 20;

  // 640x480 @ 60 Hz
  localparam int VID480_HPIX     = 640;
  localparam int VID480_H_FRONT  = 16;
  localparam int VID480_H_SYNC   = 96;
  localparam int VID480_H_BACK   = 48;
  localparam int VID480_VPIX     = 480;
  localparam int VID480_V_FRONT  = 10;
  localparam int VID480_V_SYNC   = 2;
  localparam int VID480_V_BACK   = 33;

endpackage

// File: rtl/video_timing_ctrl_wrap_counter.sv
// Modulo-MAX counter with synchronous clear; out_wrap flags the enabled
// cycle in which the count returns to zero.
module wrap_counter
  import video_pkg::*;
#(
  parameter int MAX  = 16,
  parameter int BITS = $clog2(MAX)
) (
  input  logic            in_clk,
  input  logic            in_rst,
  input  logic            in_clear,
  input  logic            in_enable,
  output logic [BITS-1:0] out_value,
  output logic            out_wrap
);

  localparam logic [BITS-1:0] LAST = BITS'(MAX - 1);

  assign out_wrap = in_enable && (out_value == LAST);

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      out_value <= '0;
    end else if (in_clear) begin
      out_value <= '0;
    end else if (in_enable) begin
      out_value <= out_wrap ? '0 : out_value + BITS'(1);
    end
  end

endmodule

// File: rtl/video_timing_ctrl.sv
// Raster timing generator: h/v counters address the pixel source, and the
// returned pixel is registered together with delay-matched syncs and strobes.
module video_timing_ctrl
  import video_pkg::*;
#(
  parameter int RED_BITS   = 5,
  parameter int GREEN_BITS = 6,
  parameter int BLUE_BITS  = 5,
  parameter int PIXEL_BITS = RED_BITS + GREEN_BITS + BLUE_BITS,
  parameter int HPIX       = VID1080_HPIX,
  parameter int H_FRONT    = VID1080_H_FRONT,
  parameter int H_SYNC     = VID1080_H_SYNC,
  parameter int H_BACK     = VID1080_H_BACK,
  parameter int VPIX       = VID1080_VPIX,
  parameter int V_FRONT    = VID1080_V_FRONT,
  parameter int V_SYNC     = VID1080_V_SYNC,
  parameter int V_BACK     = VID1080_V_BACK,
  parameter bit SYNC_POL   = 1'b1,
  parameter int HCTR_BITS  = $clog2(HPIX),
  parameter int VCTR_BITS  = $clog2(VPIX),
  parameter int FRAME_BITS = 16
) (
  input  logic                  in_clk,
  input  logic                  in_rst,
  input  logic                  in_enable,
  input  logic [PIXEL_BITS-1:0] in_pattern,
  output logic [HCTR_BITS-1:0]  out_hpix,
  output logic [VCTR_BITS-1:0]  out_vpix,
  output logic [PIXEL_BITS-1:0] out_pixel,
  output logic                  out_hsync,
  output logic                  out_vsync,
  output logic                  out_active,
  output logic                  out_line_start,
  output logic                  out_frame_start,
  output logic                  out_running,
  output logic [FRAME_BITS-1:0] out_frame
);

  localparam int H_TOTAL = vid_total(HPIX, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = vid_total(VPIX, V_FRONT, V_SYNC, V_BACK);
  localparam int HB      = $clog2(H_TOTAL);
  localparam int VB      = $clog2(V_TOTAL);

  localparam logic [HB-1:0] H_ACT  = HB'(HPIX);
  localparam logic [HB-1:0] HS_ON  = HB'(HPIX + H_FRONT);
  localparam logic [HB-1:0] HS_OFF = HB'(HPIX + H_FRONT + H_SYNC);
  localparam logic [VB-1:0] V_ACT  = VB'(VPIX);
  localparam logic [VB-1:0] VS_ON  = VB'(VPIX + V_FRONT);
  localparam logic [VB-1:0] VS_OFF = VB'(VPIX + V_FRONT + V_SYNC);

  t_vid_state    state;
  logic [HB-1:0] h;
  logic [VB-1:0] v;
  logic          h_wrap;
  logic          v_wrap;
  logic          counting;
  logic          active0;
  logic          hsync0;
  logic          vsync0;

  assign counting = (state != IDLE);

  // Counters sit at zero while idle so every start presents (0,0) first.
  wrap_counter #(.MAX(H_TOTAL), .BITS(HB)) u_hcount (
    .in_clk    (in_clk),
    .in_rst    (in_rst),
    .in_clear  (!counting),
    .in_enable (counting),
    .out_value (h),
    .out_wrap  (h_wrap)
  );

  wrap_counter #(.MAX(V_TOTAL), .BITS(VB)) u_vcount (
    .in_clk    (in_clk),
    .in_rst    (in_rst),
    .in_clear  (!counting),
    .in_enable (h_wrap),
    .out_value (v),
    .out_wrap  (v_wrap)
  );

  assign active0  = counting && (h < H_ACT) && (v < V_ACT);
  assign hsync0   = counting && (h >= HS_ON) && (h < HS_OFF);
  assign vsync0   = counting && (v >= VS_ON) && (v < VS_OFF);
  assign out_hpix = active0 ? HCTR_BITS'(h) : '0;
  assign out_vpix = active0 ? VCTR_BITS'(v) : '0;

  // Stop requests are deferred to the end-of-frame wrap via DRAIN.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state       <= IDLE;
      out_running <= 1'b0;
      out_frame   <= '0;
    end else begin
      if (v_wrap) begin
        out_frame <= out_frame + FRAME_BITS'(1);
      end
      case (state)
        IDLE: begin
          if (in_enable) begin
            state       <= RUN;
            out_running <= 1'b1;
          end
        end
        RUN: begin
          if (!in_enable) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (in_enable) begin
            state <= RUN;
          end else if (v_wrap) begin
            state       <= IDLE;
            out_running <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          out_running <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      out_pixel       <= '0;
      out_active      <= 1'b0;
      out_hsync       <= ~SYNC_POL;
      out_vsync       <= ~SYNC_POL;
      out_line_start  <= 1'b0;
      out_frame_start <= 1'b0;
    end else begin
      out_pixel       <= active0 ? in_pattern : '0;
      out_active      <= active0;
      out_hsync       <= hsync0 ^ ~SYNC_POL;
      out_vsync       <= vsync0 ^ ~SYNC_POL;
      out_line_start  <= active0 && (h == '0);
      out_frame_start <= active0 && (h == '0) && (v == '0);
    end
  end

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Directed bench for video_timing_ctrl on a 14x7 raster; a second instance
// uses inverted sync polarity and a 4-bit frame counter to reach the wrap.
module tb_video_timing_ctrl;

  localparam int HT = 14;
  localparam int VT = 7;
  localparam int FT = HT * VT;

  logic        in_clk;
  logic        in_rst;
  logic        in_enable;
  logic [15:0] pat_a, pat_b;
  logic [2:0]  hpix_a, hpix_b;
  logic [1:0]  vpix_a, vpix_b;
  logic [15:0] pixel_a, pixel_b;
  logic        hsync_a, hsync_b, vsync_a, vsync_b;
  logic        active_a, active_b, lstart_a, lstart_b, fstart_a, fstart_b;
  logic        running_a, running_b;
  logic [15:0] frame_a;
  logic [3:0]  frame_b;

  int checks = 0;
  int passed = 0;

  // The pattern source returns an address-derived word with a nonzero marker.
  assign pat_a = 16'hA000 | {11'd0, hpix_a, vpix_a};
  assign pat_b = 16'hA000 | {11'd0, hpix_b, vpix_b};

  video_timing_ctrl #(
    .RED_BITS(5), .GREEN_BITS(6), .BLUE_BITS(5), .PIXEL_BITS(16),
    .HPIX(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .VPIX(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_POL(1'b1), .HCTR_BITS(3), .VCTR_BITS(2), .FRAME_BITS(16)
  ) dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_enable(in_enable), .in_pattern(pat_a),
    .out_hpix(hpix_a), .out_vpix(vpix_a), .out_pixel(pixel_a),
    .out_hsync(hsync_a), .out_vsync(vsync_a), .out_active(active_a),
    .out_line_start(lstart_a), .out_frame_start(fstart_a),
    .out_running(running_a), .out_frame(frame_a)
  );

  video_timing_ctrl #(
    .RED_BITS(5), .GREEN_BITS(6), .BLUE_BITS(5), .PIXEL_BITS(16),
    .HPIX(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .VPIX(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_POL(1'b0), .HCTR_BITS(3), .VCTR_BITS(2), .FRAME_BITS(4)
  ) dut_neg (
    .in_clk(in_clk), .in_rst(in_rst), .in_enable(in_enable), .in_pattern(pat_b),
    .out_hpix(hpix_b), .out_vpix(vpix_b), .out_pixel(pixel_b),
    .out_hsync(hsync_b), .out_vsync(vsync_b), .out_active(active_b),
    .out_line_start(lstart_b), .out_frame_start(fstart_b),
    .out_running(running_b), .out_frame(frame_b)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs == exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, obs, exp, $time);
  endtask

  task automatic applyStimulus(input logic rst, input logic en);
    in_rst    = rst;
    in_enable = en;
  endtask

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  // p: raster position shown at stage 1 (-1 = nothing), q: position held in
  // the counters (-1 = idle), f: completed frames.
  task automatic checkRaster(input int p, input int q, input int f);
    int ph, pv, qh, qv, pix;
    bit act, hs, vs, aact;
    ph   = (p >= 0) ? (p % FT) % HT : 0;
    pv   = (p >= 0) ? (p % FT) / HT : 0;
    qh   = (q >= 0) ? (q % FT) % HT : 0;
    qv   = (q >= 0) ? (q % FT) / HT : 0;
    act  = (p >= 0) && (ph < 8) && (pv < 4);
    hs   = (p >= 0) && (ph == 10 || ph == 11);
    vs   = (p >= 0) && (pv == 5);
    aact = (q >= 0) && (qh < 8) && (qv < 4);
    pix  = act ? (32'hA000 | (ph << 2) | pv) : 0;
    checkOutput("pixel", int'(pixel_a), pix);
    checkOutput("active", int'(active_a), int'(act));
    checkOutput("hsync", int'(hsync_a), int'(hs));
    checkOutput("vsync", int'(vsync_a), int'(vs));
    checkOutput("line_start", int'(lstart_a), int'(act && ph == 0));
    checkOutput("frame_start", int'(fstart_a), int'(act && ph == 0 && pv == 0));
    checkOutput("running", int'(running_a), int'(q >= 0));
    checkOutput("hpix", int'(hpix_a), aact ? qh : 0);
    checkOutput("vpix", int'(vpix_a), aact ? qv : 0);
    checkOutput("frame", int'(frame_a), f % 65536);
    checkOutput("pixel_neg", int'(pixel_b), pix);
    checkOutput("hsync_neg", int'(hsync_b), int'(!hs));
    checkOutput("vsync_neg", int'(vsync_b), int'(!vs));
    checkOutput("frame_neg", int'(frame_b), f % 16);
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0);
    #3;
    applyStimulus(1'b0, 1'b0);
    #1;
    checkRaster(-1, -1, 0);
    repeat (3) tick();
    checkRaster(-1, -1, 0);
    applyStimulus(1'b1, 1'b0);
    tick();
    tick();
    checkRaster(-1, -1, 0);

    // First frame, then a stop request at (3,1) of the second frame.
    applyStimulus(1'b1, 1'b1);
    tick();
    checkRaster(-1, 0, 0);
    for (int q = 1; q <= 196; q++) begin
      tick();
      checkRaster(q - 1, (q == 196) ? -1 : q, q / FT);
      if (q == FT + 17) applyStimulus(1'b1, 1'b0);
    end
    tick();
    checkRaster(-1, -1, 2);
    tick();
    checkRaster(-1, -1, 2);

    // Stop at (3,1), resume at (0,5) before the wrap: no gap expected.
    applyStimulus(1'b1, 1'b1);
    tick();
    checkRaster(-1, 0, 2);
    for (int q = 1; q <= FT + 33; q++) begin
      tick();
      checkRaster(q - 1, q, 2 + q / FT);
      if (q == 17) applyStimulus(1'b1, 1'b0);
      if (q == 70) applyStimulus(1'b1, 1'b1);
    end

    // Asynchronous reset while the counters sit at (5,2).
    applyStimulus(1'b0, 1'b0);
    #2;
    checkRaster(-1, -1, 0);
    tick();
    checkRaster(-1, -1, 0);
    applyStimulus(1'b1, 1'b0);
    tick();
    checkRaster(-1, -1, 0);

    // Restart from (0,0) and run 17 frames so the 4-bit counter wraps to 1.
    applyStimulus(1'b1, 1'b1);
    tick();
    checkRaster(-1, 0, 0);
    for (int q = 1; q <= 17 * FT; q++) begin
      tick();
      checkRaster(q - 1, q, q / FT);
    end
    checkOutput("frame_wrap_neg", int'(frame_b), 1);
    checkOutput("frame_after_17", int'(frame_a), 17);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
